bp_fe_fetch_buffer: RTL
=======================

BP_FE_FETCH_BUFFER -- requirements
Module: bp_fe_fetch_buffer

Interface
REQ-001 Parameter els_p, default 4, SHALL set the buffer depth in entries; legal range is 2 or more, and it need not be a power of 2.
REQ-002 Parameter vaddr_width_p, default 39, SHALL set the fetch PC width.
REQ-003 Parameter instr_width_p, default 32, SHALL set the instruction width.
REQ-004 Parameter metadata_width_p, default 36, SHALL set the branch-metadata width (branch_metadata_fwd_width_p).
REQ-005 The module SHALL have one clock and an asynchronous, active-high reset.
REQ-006 Port list (name, direction, width, meaning):
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous, active-high reset.
- flush_i  in  1  redirect from the backend; discards all entries.
- enq_v_i  in  1  the fetch stage presents an entry.
- enq_ready_o  out  1  the buffer accepts an entry this cycle.
- enq_pc_i  in  vaddr_width_p  fetch PC.
- enq_instr_i  in  instr_width_p  fetched instruction.
- enq_metadata_i  in  metadata_width_p  branch metadata.
- enq_exception_i  in  1  entry is a fetch exception.
- deq_v_o  out  1  head entry is valid.
- deq_yumi_i  in  1  the consumer takes the head entry.
- deq_pc_o  out  vaddr_width_p  head entry PC.
- deq_instr_o  out  instr_width_p  head entry instruction.
- deq_metadata_o  out  metadata_width_p  head entry metadata.
- deq_exception_o  out  1  head entry exception flag.
- count_o  out  $clog2(els_p+1)  current occupancy.

Function
REQ-007 Storage SHALL be a circular buffer of els_p entries, each {pc, instr, metadata, exception}, with read pointer rptr, write pointer wptr and occupancy count.
REQ-008 Both pointers SHALL increment modulo els_p, wrapping from els_p-1 to 0.
REQ-009 An enqueue SHALL occur when enq_v_i & enq_ready_o & ~flush_i; the entry is written at wptr and wptr advances.
REQ-010 A dequeue SHALL occur when deq_yumi_i & deq_v_o & ~flush_i; rptr advances.
REQ-011 enq_ready_o SHALL equal (count != els_p), depend only on registered state, and have no combinational path from deq_yumi_i or flush_i.
REQ-012 When full, enq_ready_o SHALL stay 0 even if a dequeue occurs in the same cycle.
REQ-013 deq_v_o SHALL equal (count != 0); deq_* data SHALL be driven from the entry at rptr, registered state only.
REQ-014 Enqueue-to-dequeue latency SHALL be 1 cycle; there is no same-cycle bypass, so an empty buffer presents deq_v_o=0 even while enq_v_i=1.
REQ-015 count update:
- enqueue only: +1
- dequeue only: -1
- both in the same cycle: unchanged, with both pointers advancing
REQ-016 flush_i SHALL take priority over enqueue and dequeue in the same cycle.
REQ-017 After a flush cycle, next cycle: count=0, rptr=wptr=0, deq_v_o=0, enq_ready_o=1; the enqueue attempted in the flush cycle is dropped.
REQ-018 Exception entries SHALL be stored and returned unmodified, including enq_instr_i bits, and SHALL be ordered like normal entries.
REQ-019 deq_yumi_i asserted while deq_v_o=0 is illegal; the design SHALL ignore it, and a simulation assertion SHALL fire.
REQ-020 enq_v_i asserted while enq_ready_o=0 SHALL write nothing and leave all state unchanged.
REQ-021 count_o SHALL never exceed els_p or underflow below 0; a simulation assertion SHALL check this.

Reset
REQ-022 reset_i SHALL asynchronously clear rptr, wptr and count to 0; outputs during reset: deq_v_o=0, enq_ready_o=1, count_o=0.
REQ-023 Entry storage SHALL NOT be reset; deq_pc_o, deq_instr_o, deq_metadata_o and deq_exception_o are don't-care while deq_v_o=0.
REQ-024 Reset asserted mid-operation SHALL discard all entries immediately; the first enqueue after deassertion lands at index 0.

Verification (els_p=4)
REQ-025 Enqueue PCs 0x80000000, 0x80000004 and 0x80000008 on consecutive cycles with deq_yumi_i=0 -> count_o 1, 2, 3; deq_pc_o=0x80000000 from the cycle after the first enqueue.
REQ-026 Fill with 4 entries, hold enq_v_i=1 and pulse deq_yumi_i -> enq_ready_o=0 in that cycle and no write; next cycle count_o=3 and enq_ready_o=1.
REQ-027 Stream 10 entries with enq_v_i=deq_yumi_i=1 continuously after the first enqueue -> count_o stays 1, PCs dequeue in order, and the pointers wrap 3->0 twice with no loss.
REQ-028 With 3 entries, assert flush_i together with enq_v_i and deq_yumi_i -> next cycle count_o=0 and deq_v_o=0; the next enqueue of PC 0x100 appears at deq_pc_o one cycle later.
REQ-029 Enqueue an entry with enq_exception_i=1, instr=0xDEADBEEF, metadata=0x5A -> dequeued with deq_exception_o=1, deq_instr_o=0xDEADBEEF, deq_metadata_o=0x5A.
REQ-030 Assert reset_i asynchronously between clock edges with 2 entries held -> deq_v_o=0 and count_o=0 before the next edge; the post-reset enqueue is read out correctly.

Source files
------------

// File: rtl/bp_fe_fetch_buffer.sv
// Fetch buffer between the frontend fetch stage and the backend.
// Circular queue of {pc, instr, metadata, exception}. Flush has priority over enqueue and dequeue.
module bp_fe_fetch_buffer #(
    parameter int els_p            = 4,
    parameter int vaddr_width_p    = 39,
    parameter int instr_width_p    = 32,
    parameter int metadata_width_p = 36,
    localparam int count_width_lp  = $clog2(els_p + 1)
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        flush_i,

    input  logic                        enq_v_i,
    output logic                        enq_ready_o,
    input  logic [vaddr_width_p-1:0]    enq_pc_i,
    input  logic [instr_width_p-1:0]    enq_instr_i,
    input  logic [metadata_width_p-1:0] enq_metadata_i,
    input  logic                        enq_exception_i,

    output logic                        deq_v_o,
    input  logic                        deq_yumi_i,
    output logic [vaddr_width_p-1:0]    deq_pc_o,
    output logic [instr_width_p-1:0]    deq_instr_o,
    output logic [metadata_width_p-1:0] deq_metadata_o,
    output logic                        deq_exception_o,

    output logic [count_width_lp-1:0]   count_o
);

    localparam int ptr_width_lp   = $clog2(els_p);
    localparam int entry_width_lp = vaddr_width_p + instr_width_p + metadata_width_p + 1;
    localparam logic [ptr_width_lp-1:0]   last_ptr_lp = ptr_width_lp'(els_p - 1);
    localparam logic [count_width_lp-1:0] full_cnt_lp = count_width_lp'(els_p);

    logic [entry_width_lp-1:0] mem_q [els_p];

    logic [ptr_width_lp-1:0]   rptr_q, rptr_d;
    logic [ptr_width_lp-1:0]   wptr_q, wptr_d;
    logic [count_width_lp-1:0] count_q, count_d;

    logic enq, deq;

    // Depth need not be a power of two, so wrap explicitly.
    function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] p);
        return (p == last_ptr_lp) ? '0 : p + 1'b1;
    endfunction

    // Handshake flags come from registered count only; no path from yumi or flush.
    assign enq_ready_o = (count_q != full_cnt_lp);
    assign deq_v_o     = (count_q != '0);
    assign count_o     = count_q;

    assign enq = enq_v_i & enq_ready_o & ~flush_i;
    assign deq = deq_yumi_i & deq_v_o & ~flush_i;

    assign {deq_pc_o, deq_instr_o, deq_metadata_o, deq_exception_o} = mem_q[rptr_q];

    always_comb begin
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        if (flush_i) begin
            rptr_d  = '0;
            wptr_d  = '0;
            count_d = '0;
        end else begin
            if (enq) wptr_d = ptr_inc(wptr_q);
            if (deq) rptr_d = ptr_inc(rptr_q);
            case ({enq, deq})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
        end
    end

    // Payload storage carries no reset; its contents are meaningless while deq_v_o is low.
    always_ff @(posedge clk_i) begin
        if (enq) mem_q[wptr_q] <= {enq_pc_i, enq_instr_i, enq_metadata_i, enq_exception_i};
    end

    a_no_yumi_when_empty: assert property (@(posedge clk_i) disable iff (reset_i)
        !(deq_yumi_i && !deq_v_o));

    a_count_in_range: assert property (@(posedge clk_i) disable iff (reset_i)
        count_q <= full_cnt_lp);

endmodule
